wb_cmd_master: RTL
==================

WB_CMD_MASTER -- requirements
Module: wb_cmd_master

Interface
REQ-001 SHALL have parameter ADDR_W, default 17, Wishbone address width (matches I/O space adr_i[16:0]).
REQ-002 SHALL have parameter TIMEOUT, default 1024, cycles from cyc_o assertion to abort, legal range 2..65535.
REQ-003 SHALL have port clk_i  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port rst_i  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port cmd_valid_i  input  1  command present.
REQ-006 SHALL have port cmd_ready_o  output  1  command accepted when high with cmd_valid_i.
REQ-007 SHALL have ports cmd_we_i (1), cmd_adr_i (ADDR_W), cmd_dat_i (32), cmd_sel_i (4), all inputs: write flag, address, write data, byte selects.
REQ-008 SHALL have port rsp_valid_o  output  1  response present.
REQ-009 SHALL have port rsp_ready_i  input  1  response consumed when high with rsp_valid_o.
REQ-010 SHALL have ports rsp_dat_o (32) and rsp_err_o (1), outputs: read data, and the timeout flag.
REQ-011 SHALL have Wishbone initiator ports cyc_o, stb_o, we_o (1 each), adr_o (ADDR_W), dat_o (32), sel_o (4) as outputs, and dat_i (32), ack_i (1) as inputs.

Function
REQ-012 SHALL implement states IDLE, BUS, RESP; 2-bit encoding.
REQ-013 SHALL drive cmd_ready_o high only in IDLE.
REQ-014 On cmd_valid_i&cmd_ready_o at edge N, SHALL register we/adr/dat/sel to the bus outputs, enter BUS, and have cyc_o=stb_o=1 from after edge N.
REQ-015 SHALL hold cyc_o, stb_o, we_o, adr_o, dat_o and sel_o stable throughout BUS.
REQ-016 In BUS, when ack_i is sampled high, SHALL deassert cyc_o/stb_o after that edge, capture rsp_dat_o=dat_i for reads (0 for writes), set rsp_err_o=0, and enter RESP.
REQ-017 SHALL count BUS cycles. If TIMEOUT cycles elapse with no ack_i, SHALL deassert cyc_o/stb_o, set rsp_dat_o=0 and rsp_err_o=1, and enter RESP.
REQ-018 If ack_i and the timeout occur on the same edge, ack SHALL win: rsp_err_o=0 and data is captured.
REQ-019 SHALL drive rsp_valid_o high only in RESP, holding rsp_dat_o and rsp_err_o stable until rsp_ready_i; on the handshake, SHALL return to IDLE.
REQ-020 SHALL issue exactly one bus transfer per command; a stale ack_i in IDLE or RESP SHALL be ignored.
REQ-021 Minimum command-to-response latency SHALL be 2 edges (accept, ack). Back-to-back throughput SHALL be one command per 3 cycles with zero-wait-state ack and rsp_ready_i tied high.
REQ-022 The timeout counter SHALL be $clog2(TIMEOUT+1) bits wide, clear on entry to BUS, and never wrap.

Reset
REQ-023 While rst_i is low, SHALL asynchronously set state=IDLE and drive cyc_o, stb_o, we_o, rsp_valid_o, rsp_err_o = 0 and adr_o, dat_o, sel_o, rsp_dat_o = 0. cmd_ready_o SHALL be high one cycle after release.
REQ-024 Reset asserted mid-BUS SHALL drop cyc_o immediately with no response generated; the pending command is discarded.

Structure
REQ-025 State encoding localparams and the default TIMEOUT value SHALL live in the shared I/O package; ADDR_W/data width constants SHALL also live there.
REQ-026 No sub-module is required; the timeout counter SHALL be inline.

Verification
REQ-027 Read against a responder acking 2 cycles after stb, dat_i=32'h1234ABCD -> single cyc_o pulse of 3 cycles, rsp_dat_o=32'h1234ABCD, rsp_err_o=0.
REQ-028 Write adr=17'h01000, dat=32'h000001FF, sel=4'hF -> bus outputs match exactly while cyc_o is high; rsp_dat_o=0, rsp_err_o=0.
REQ-029 No ack with TIMEOUT=16 -> cyc_o high exactly 16 cycles, then rsp_err_o=1 and rsp_dat_o=0.
REQ-030 ack_i on the final timeout cycle -> rsp_err_o=0 and data captured. ack_i pulsed in IDLE -> no state change.
REQ-031 rsp_ready_i held low for 10 cycles -> rsp_valid_o and data stable, cmd_ready_o=0, and a new command is not accepted.
REQ-032 rst_i low mid-BUS -> cyc_o=0 in the same cycle with no rsp_valid_o; after release, the next command completes normally.

Source files
------------

// File: rtl/wb_cmd_master_pkg.sv
// -----------------------------------------------------------------------------
// wb_cmd_master_pkg
// Shared constants and types for the Wishbone command master:
//   - default address width and timeout
//   - data and byte-select widths
//   - 2-bit state encoding of the transfer FSM
// -----------------------------------------------------------------------------
package wb_cmd_master_pkg;

  // Bus geometry. The default address width covers the 128 KiB I/O window.
  localparam int ADDR_W_DEF  = 17;
  localparam int DATA_W      = 32;
  localparam int SEL_W       = DATA_W / 8;

  // Default number of cycles a transfer may stay on the bus before abort.
  localparam int TIMEOUT_DEF = 1024;

  // State encoding of the transfer FSM.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUS  = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    BUS  = ST_BUS,
    RESP = ST_RESP
  } state_e;

endpackage : wb_cmd_master_pkg

// File: rtl/wb_cmd_master.sv
// -----------------------------------------------------------------------------
// wb_cmd_master
// Converts a valid/ready command stream into single Wishbone classic transfers
// and returns one response (read data or timeout flag) per command.
//
// Ports
//   clk_i, rst_i          clock; asynchronous active-low reset
//   cmd_valid_i/ready_o   command handshake (ready only while idle)
//   cmd_we_i/adr_i/dat_i/sel_i   command fields
//   rsp_valid_o/ready_i   response handshake
//   rsp_dat_o, rsp_err_o  read data (0 for writes/timeouts), timeout flag
//   cyc_o, stb_o, we_o, adr_o, dat_o, sel_o   Wishbone initiator outputs
//   dat_i, ack_i          Wishbone initiator inputs
// -----------------------------------------------------------------------------
module wb_cmd_master
  import wb_cmd_master_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,

  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic              cmd_we_i,
  input  logic [ADDR_W-1:0] cmd_adr_i,
  input  logic [DATA_W-1:0] cmd_dat_i,
  input  logic [SEL_W-1:0]  cmd_sel_i,

  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [DATA_W-1:0] rsp_dat_o,
  output logic              rsp_err_o,

  output logic              cyc_o,
  output logic              stb_o,
  output logic              we_o,
  output logic [ADDR_W-1:0] adr_o,
  output logic [DATA_W-1:0] dat_o,
  output logic [SEL_W-1:0]  sel_o,
  input  logic [DATA_W-1:0] dat_i,
  input  logic              ack_i
);

  // Wide enough to hold TIMEOUT itself, so the count can never wrap.
  localparam int               CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

  state_e state_q, state_d;

  logic              we_q;
  logic [ADDR_W-1:0] adr_q;
  logic [DATA_W-1:0] dat_q;
  logic [SEL_W-1:0]  sel_q;
  logic [DATA_W-1:0] rsp_dat_q;
  logic              rsp_err_q;
  logic [CNT_W-1:0]  tmo_cnt_q;

  logic accept;
  logic timeout_hit;

  assign accept      = (state_q == IDLE) && cmd_valid_i;
  // The counter starts at 0 on the first BUS cycle, so reaching TIMEOUT-1
  // means this edge closes the TIMEOUT-th cycle with cyc_o high.
  assign timeout_hit = (tmo_cnt_q == TMO_LAST);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: state_d gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (cmd_valid_i)          state_d = BUS;
      BUS:     if (ack_i || timeout_hit) state_d = RESP;
      RESP:    if (rsp_ready_i)          state_d = IDLE;
      default:                           state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output decode: strobes come straight from the state flops, so a reset
  // mid-transfer drops cyc_o immediately and never shows a response.
  // ---------------------------------------------------------------------------
  always_comb begin
    cmd_ready_o = 1'b0;
    rsp_valid_o = 1'b0;
    cyc_o       = 1'b0;
    stb_o       = 1'b0;
    unique case (state_q)
      IDLE:    cmd_ready_o = 1'b1;
      BUS: begin
        cyc_o = 1'b1;
        stb_o = 1'b1;
      end
      RESP:    rsp_valid_o = 1'b1;
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Command capture, timeout counter and response capture.
  // Bus fields load only on accept, so they stay stable throughout BUS;
  // the response loads only on the BUS exit edge, so it is stable in RESP
  // and stale acks outside BUS have no effect.
  // ---------------------------------------------------------------------------
  // NOTE: these data registers do carry a reset: the bus and response outputs
  // must read as zero while rst_i is low.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      we_q      <= 1'b0;
      adr_q     <= '0;
      dat_q     <= '0;
      sel_q     <= '0;
      rsp_dat_q <= '0;
      rsp_err_q <= 1'b0;
      tmo_cnt_q <= '0;
    end else if (accept) begin
      we_q      <= cmd_we_i;
      adr_q     <= cmd_adr_i;
      dat_q     <= cmd_dat_i;
      sel_q     <= cmd_sel_i;
      tmo_cnt_q <= '0;
    end else if (state_q == BUS) begin
      if (ack_i) begin
        // Ack wins over a simultaneous timeout.
        rsp_dat_q <= we_q ? '0 : dat_i;
        rsp_err_q <= 1'b0;
      end else if (timeout_hit) begin
        rsp_dat_q <= '0;
        rsp_err_q <= 1'b1;
      end else if (tmo_cnt_q != TMO_LAST) begin
        tmo_cnt_q <= tmo_cnt_q + 1'b1;
      end
    end
  end

  assign we_o      = we_q;
  assign adr_o     = adr_q;
  assign dat_o     = dat_q;
  assign sel_o     = sel_q;
  assign rsp_dat_o = rsp_dat_q;
  assign rsp_err_o = rsp_err_q;

endmodule : wb_cmd_master
